// File: rtl/axis_sample_buffer.sv
// Elastic sample FIFO: absorbs a producer that ignores ready and re-emits on an AXI4-Stream master.
// Latency one cycle from push into an empty FIFO to m_axis_valid; words arriving while full are dropped and counted.
module axis_sample_buffer #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH_LOG2 = 3,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic [OVF_WIDTH-1:0]  o_drop_count,
    output logic                  o_pair_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                  mem_q [DEPTH];
    entry_t                  mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic [OVF_WIDTH-1:0]    drop_q, drop_d;
    logic                    prev_last_q, prev_last_d;
    logic                    pair_err_q, pair_err_d;

    logic   full;
    logic   push;
    logic   pop;
    logic   drop;
    entry_t head;

    assign full = (level_q == FULL_LVL);
    // Fullness is judged on the registered level only, so a same-cycle pop never makes room.
    assign push = s_axis_valid && !full;
    assign drop = s_axis_valid && full;
    assign pop  = m_axis_valid && m_axis_ready;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        drop_d      = drop_q;
        prev_last_d = prev_last_q;
        pair_err_d  = pair_err_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{last: s_axis_last, data: s_axis_data};
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
            prev_last_d     = s_axis_last;
            if (s_axis_last == prev_last_q) begin
                pair_err_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
            default: level_d = level_q;
        endcase

        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + OVF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_q      <= '0;
            prev_last_q <= 1'b1;
            pair_err_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_q      <= drop_d;
            prev_last_q <= prev_last_d;
            pair_err_q  <= pair_err_d;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign m_axis_valid = (level_q != '0);
    // Output is forced to zero while empty so stale storage never shows on the bus.
    assign m_axis_data  = m_axis_valid ? head.data : '0;
    assign m_axis_last  = m_axis_valid ? head.last : 1'b0;
    assign s_axis_ready = !full && !rst;
    assign o_level      = level_q;
    assign o_drop_count = drop_q;
    assign o_pair_error = pair_err_q;

endmodule

// File: tb/tb_axis_sample_buffer.sv
// Bench for axis_sample_buffer: vector table for the main stream, scoreboard on every handshake,
// plus hand-written sequences for drop-counter saturation and mid-stream reset.
module tb_axis_sample_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [3:0]  level;
    logic [15:0] drop_cnt;
    logic        pair_err;

    logic [23:0] sat_s_data;
    logic        sat_s_valid;
    logic        sat_s_ready;
    logic [23:0] sat_m_data;
    logic        sat_m_valid;
    logic        sat_m_last;
    logic [1:0]  sat_level;
    logic [3:0]  sat_drop;
    logic        sat_pair_err;

    always #5 clk = ~clk;

    axis_sample_buffer #(.DATA_WIDTH(24), .DEPTH_LOG2(3), .OVF_WIDTH(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_data),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .s_axis_last  (s_last),
        .m_axis_data  (m_data),
        .m_axis_valid (m_valid),
        .m_axis_ready (m_ready),
        .m_axis_last  (m_last),
        .o_level      (level),
        .o_drop_count (drop_cnt),
        .o_pair_error (pair_err)
    );

    axis_sample_buffer #(.DATA_WIDTH(24), .DEPTH_LOG2(1), .OVF_WIDTH(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (sat_s_data),
        .s_axis_valid (sat_s_valid),
        .s_axis_ready (sat_s_ready),
        .s_axis_last  (1'b0),
        .m_axis_data  (sat_m_data),
        .m_axis_valid (sat_m_valid),
        .m_axis_ready (1'b0),
        .m_axis_last  (sat_m_last),
        .o_level      (sat_level),
        .o_drop_count (sat_drop),
        .o_pair_error (sat_pair_err)
    );

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        l;
        logic        r;
        logic [3:0]  exp_lvl;
        logic        exp_mv;
        logic [23:0] exp_dat;
        logic [15:0] exp_drop;
        logic        exp_srdy;
        logic        exp_perr;
    } vec_t;

    vec_t        vecs[$];
    logic [24:0] sb[$];
    int          model_lvl;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [23:0] d, input logic l, input logic r,
                       input logic [3:0] lvl, input logic mv, input logic [23:0] dat,
                       input logic [15:0] drp, input logic srdy);
        vecs.push_back('{v: v, d: d, l: l, r: r, exp_lvl: lvl, exp_mv: mv, exp_dat: dat,
                         exp_drop: drp, exp_srdy: srdy, exp_perr: 1'b0});
    endtask

    // Called at a falling edge: drives the inputs for the next rising edge and keeps the scoreboard.
    task automatic step(input logic v, input logic [23:0] d, input logic l, input logic r);
        logic [24:0] exp_w;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = r;
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pop", {7'd0, m_last, m_data}, 32'hFFFF_FFFF);
            end else begin
                exp_w = sb.pop_front();
                chk("sb_data", {8'd0, m_data}, {8'd0, exp_w[23:0]});
                chk("sb_last", {31'd0, m_last}, {31'd0, exp_w[24]});
            end
        end
        if (v && model_lvl < 8) begin
            sb.push_back({l, d});
        end
        model_lvl = model_lvl + ((v && model_lvl < 8) ? 1 : 0) - ((model_lvl != 0 && r) ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_lvl   = 0;
        rst         = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        m_ready     = 1'b0;
        sat_s_valid = 1'b0;
        sat_s_data  = '0;

        // Single word, then a right word to keep the L/R pairing intact.
        add(1, 24'h123456, 0, 1, 1, 1, 24'h123456, 0, 1);
        add(0, 24'h0,      0, 1, 0, 0, 24'h0,      0, 1);
        add(1, 24'h654321, 1, 1, 1, 1, 24'h654321, 0, 1);
        add(0, 24'h0,      0, 1, 0, 0, 24'h0,      0, 1);
        // Backpressure: data frozen on the oldest word, then in-order drain.
        add(1, 24'hA00000, 0, 0, 1, 1, 24'hA00000, 0, 1);
        add(1, 24'hA00001, 1, 0, 2, 1, 24'hA00000, 0, 1);
        add(1, 24'hA00002, 0, 0, 3, 1, 24'hA00000, 0, 1);
        add(0, 24'h0,      0, 0, 3, 1, 24'hA00000, 0, 1);
        add(0, 24'h0,      0, 1, 2, 1, 24'hA00001, 0, 1);
        add(0, 24'h0,      0, 1, 1, 1, 24'hA00002, 0, 1);
        add(0, 24'h0,      0, 1, 0, 0, 24'h0,      0, 1);
        // Overflow: ten words into eight slots.
        for (int i = 0; i < 10; i++) begin
            add(1, 24'hB00000 + 24'(i), (i % 2 == 0), 0,
                4'((i + 1 > 8) ? 8 : i + 1), 1, 24'hB00000,
                16'((i >= 8) ? i - 7 : 0), (i + 1 < 8));
        end
        // Full with simultaneous pop and push: the push is still dropped.
        add(1, 24'hC00000, 0, 1, 7, 1, 24'hB00001, 3, 1);
        for (int k = 0; k < 7; k++) begin
            add(0, 24'h0, 0, 1, 4'(6 - k), (k < 6), (k < 6) ? 24'hB00002 + 24'(k) : 24'h0, 3, 1);
        end

        @(negedge clk);
        chk("rst_mvalid", {31'd0, m_valid}, 0);
        chk("rst_mdata",  {8'd0, m_data}, 0);
        chk("rst_mlast",  {31'd0, m_last}, 0);
        chk("rst_level",  {28'd0, level}, 0);
        chk("rst_drop",   {16'd0, drop_cnt}, 0);
        chk("rst_perr",   {31'd0, pair_err}, 0);
        chk("rst_sready", {31'd0, s_ready}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_sready", {31'd0, s_ready}, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
            chk($sformatf("v%0d_level", i),  {28'd0, level},    {28'd0, vecs[i].exp_lvl});
            chk($sformatf("v%0d_mvalid", i), {31'd0, m_valid},  {31'd0, vecs[i].exp_mv});
            chk($sformatf("v%0d_mdata", i),  {8'd0, m_data},    {8'd0, vecs[i].exp_dat});
            chk($sformatf("v%0d_drop", i),   {16'd0, drop_cnt}, {16'd0, vecs[i].exp_drop});
            chk($sformatf("v%0d_sready", i), {31'd0, s_ready},  {31'd0, vecs[i].exp_srdy});
            chk($sformatf("v%0d_perr", i),   {31'd0, pair_err}, {31'd0, vecs[i].exp_perr});
        end
        chk("sb_empty", sb.size(), 0);

        // Saturation on the 4-bit counter: two words fill DEPTH=2, then twenty drops.
        for (int k = 1; k <= 22; k++) begin
            sat_s_valid = 1'b1;
            sat_s_data  = 24'h500000 + 24'(k);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("sat_drop_%0d", k), {28'd0, sat_drop},
                (k - 2 > 15) ? 15 : ((k > 2) ? k - 2 : 0));
        end
        sat_s_valid = 1'b0;
        chk("sat_level", {30'd0, sat_level}, 2);
        chk("sat_head",  {8'd0, sat_m_data}, 32'h500001);

        // Pairing: two lefts set the sticky error; later valid pairs leave it set.
        rst = 1'b1;
        sb.delete();
        model_lvl = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("pr_perr0", {31'd0, pair_err}, 0);
        chk("pr_drop0", {16'd0, drop_cnt}, 0);
        step(1, 24'hD00000, 0, 0);
        chk("pr_first_left", {31'd0, pair_err}, 0);
        step(1, 24'hD00001, 0, 0);
        chk("pr_two_left", {31'd0, pair_err}, 1);
        step(1, 24'hD00002, 1, 0);
        step(1, 24'hD00003, 0, 0);
        chk("pr_sticky", {31'd0, pair_err}, 1);
        chk("pr_level",  {28'd0, level}, 4);
        step(0, 24'h0, 0, 1);
        chk("pr_drain_level", {28'd0, level}, 3);

        // Asynchronous reset in the middle of a drain.
        #2;
        rst = 1'b1;
        #1;
        chk("ar_mvalid", {31'd0, m_valid}, 0);
        chk("ar_mdata",  {8'd0, m_data}, 0);
        chk("ar_mlast",  {31'd0, m_last}, 0);
        chk("ar_level",  {28'd0, level}, 0);
        chk("ar_drop",   {16'd0, drop_cnt}, 0);
        chk("ar_perr",   {31'd0, pair_err}, 0);
        chk("ar_sready", {31'd0, s_ready}, 0);
        chk("ar_sat_drop", {28'd0, sat_drop}, 0);
        sb.delete();
        model_lvl = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 24'hE00000, 0, 1);
        chk("post_rst_data", {8'd0, m_data}, 32'hE00000);
        chk("post_rst_perr", {31'd0, pair_err}, 0);
        step(0, 24'h0, 0, 1);
        chk("post_rst_level", {28'd0, level}, 0);
        chk("post_rst_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_sample_buffer.md
# axis_sample_buffer

Receive-side elastic buffer for the audio sample path. It accepts samples from a producer that pulses valid without honouring ready, such as the volume controller output. It holds them in a small FIFO and re-emits them on a fully AXI4-Stream-compliant master port, so valid is held until the handshake. It sits between the volume controller and the I2S2 transmit path and counts every sample it has to drop.

## Interface
- DATA_WIDTH, 24, audio sample width in bits
- DEPTH_LOG2, 3, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 words (default 8)
- OVF_WIDTH, 16, width of the saturating drop counter

Ports:
- clk  in  1  sole clock; all logic is rising-edge
- rst  in  1  reset, asynchronous, active-high
- s_axis_data  in  DATA_WIDTH  incoming sample
- s_axis_valid  in  1  incoming sample strobe (the producer may ignore ready)
- s_axis_ready  out  1  high when the FIFO can accept a word
- s_axis_last  in  1  high on the right-channel sample of a stereo pair
- m_axis_data  out  DATA_WIDTH  buffered sample
- m_axis_valid  out  1  held high until the handshake completes
- m_axis_ready  in  1  downstream ready
- m_axis_last  out  1  last flag travelling with m_axis_data
- o_level  out  DEPTH_LOG2+1  words held, 0..DEPTH, including the presented word
- o_drop_count  out  OVF_WIDTH  saturating count of dropped input words
- o_pair_error  out  1  sticky: L/R alternation violated among accepted words

## Operation
- Storage: DEPTH entries of {last, data}; write pointer, read pointer and level counter.
- Write (push): on a rising edge with s_axis_valid=1 and level<DEPTH.
- Read (pop): on a rising edge with m_axis_valid=1 and m_axis_ready=1.
- Simultaneous push and pop: both occur and level is unchanged.
- Full, no pop: when level==DEPTH and s_axis_valid=1, the word is dropped and o_drop_count increments. This applies even if a pop happens in the same cycle; there is no write-through when full.
- o_drop_count saturates at all-ones and never wraps.
- s_axis_ready = (level<DEPTH) and not rst; combinational from registered level.
- m_axis_valid = (level!=0).
- m_axis_data and m_axis_last show the oldest word; they are stable while valid is high and ready is low.
- Pointers wrap modulo DEPTH; level never exceeds DEPTH and never underflows.
- Pair checker tracks the last flag of the previously accepted word (initial expected value = 1, so the first accepted word must be left, last=0).
  - An accepted word whose last equals the previous accepted word's last sets o_pair_error.
  - o_pair_error is cleared only by rst.
  - Dropped words are not checked and do not update the tracker.
- Data passes through unaltered; no arithmetic on samples.

## Timing
- Reset values: m_axis_valid=0, m_axis_data=0, m_axis_last=0, o_level=0, o_drop_count=0, o_pair_error=0; s_axis_ready=0 while rst is high.
- Reset asserted mid-stream clears all contents immediately (asynchronously). Words in flight are discarded and not counted as drops.
- Latency: a word pushed into an empty FIFO at edge N drives m_axis_valid=1 and its data in the cycle after edge N.
- A pop at edge N presents the next word, if level>1, in the cycle after edge N. This allows sustained 1 word/cycle throughput.
- o_level, o_drop_count and o_pair_error update on the same edge as the event that causes them.

## Test plan
- Single word: after reset, push 0x123456 with last=0, m_axis_ready=1 -> m_axis_valid high the next cycle with data 0x123456; popped on the following edge; o_level 0->1->0.
- Backpressure hold: m_axis_ready=0, push 3 words (L, R, L) -> m_axis_valid stays high; data is frozen on word 0; o_level=3; raise ready -> words emerge in order, one per cycle.
- Overflow: m_axis_ready=0, push 10 words with DEPTH=8 -> o_level=8, o_drop_count=2, s_axis_ready=0; drain -> exactly the first 8 words come out, in order.
- Full plus simultaneous pop/push: level=8, m_axis_ready=1 and s_axis_valid=1 on the same edge -> o_level=7, o_drop_count increments by 1.
- Saturation: OVF_WIDTH=4, force 20 drops -> o_drop_count holds at 15.
- Pairing and reset: push last=0,0 -> o_pair_error=1 and stays 1 through further valid pairs; assert rst mid-drain -> all outputs return to their reset values within the reset cycle, and o_pair_error=0.
